mac_accumulator: RTL

Downstream consumer of the combinational multiplier stage. Takes the DATA_WIDTH-bit product stream over a valid/ready handshake and sums a programmed number of products into a wide accumulator. Presents the finished sum, plus a sticky overflow flag, on a valid/ready output handshake. Together the two form the datapath's dot-product / MAC unit.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_accumulator.sv | 90 +++++++++
 2 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: FSM state encoding and default widths,
// reused by both the multiplier wrapper and the accumulator.
package mac_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ACC_WIDTH  = 40;
    localparam int unsigned LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } mac_state_e;

endpackage

// File: rtl/mac_accumulator.sv
// Sums a programmed number of unsigned products into a wide wrapping accumulator and
// hands the result, with a sticky carry-out flag, to a valid/ready consumer.
module mac_accumulator #(
    parameter int unsigned DATA_WIDTH = mac_pkg::DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = mac_pkg::ACC_WIDTH,
    parameter int unsigned LEN_WIDTH  = mac_pkg::LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [LEN_WIDTH-1:0]  len_in,
    input  logic [DATA_WIDTH-1:0] prod_in,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [ACC_WIDTH-1:0]  sum_out,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic                  overflow_out,
    output logic                  busy_out
);
    import mac_pkg::*;

    mac_state_e             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH:0]     add_full;
    logic                   prod_hs;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign add_full = {1'b0, acc_q} + {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, prod_in};
    assign prod_hs  = prod_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len_in;
                    state_d = (len_in != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (prod_hs) begin
                    acc_d = add_full[ACC_WIDTH-1:0];
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (add_full[ACC_WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every output is a register or a pure decode of the state register.
    assign prod_ready   = (state_q == ACCUM);
    assign sum_valid    = (state_q == DONE);
    assign busy_out     = (state_q != IDLE);
    assign sum_out      = acc_q;
    assign overflow_out = ovf_q;

endmodule
